xor_unit_arbiter: RTL

//  Shares one registered multi-bit XOR unit among N_REQ requesters.
//  - Round-robin arbitration; valid/ready handshake on request and response sides.
//  - Sits between client blocks and the XOR datapath.
//  - Sequences one operation at a time: grant, execute for LATENCY cycles, hold the result until it is consumed.

---
 rtl/xor_unit_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter in front of one shared, registered XOR unit: grant, execute
// for LATENCY cycles, then hold the result until consumed. Define XOR_ARB_PARITY_EN for rsp_parity.
module xor_unit_arbiter #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
`ifdef XOR_ARB_PARITY_EN
  output logic                   rsp_parity,
`endif
  output logic                   busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                       state, state_n;
  logic [N_REQ-1:0][WIDTH-1:0]  a_v, b_v;
  logic [WIDTH-1:0]             a_q, b_q;
  logic [ID_W-1:0]              id_q, last;
  logic [CNT_W-1:0]             cnt;
  logic [N_REQ-1:0]             gnt;
  logic [ID_W-1:0]              gnt_id;

  assign a_v = req_a;
  assign b_v = req_b;

  // Scan from last+1 upward with wrap; first valid requester wins.
  always_comb begin
    logic [ID_W:0]   s;
    logic [ID_W-1:0] idx;
    logic            found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    s      = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      s = (ID_W+1)'(last) + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(N_REQ)) s = s - (ID_W+1)'(N_REQ);
      idx = s[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  // Gated by rst_n so every output reads 0 the moment reset is asserted.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|gnt)          state_n = EXEC;
      EXEC:    if (cnt == '0)     state_n = RESP;
      RESP:    if (rsp_ready)     state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      cnt        <= '0;
      last       <= ID_W'(N_REQ-1);
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
`ifdef XOR_ARB_PARITY_EN
      rsp_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          a_q  <= a_v[gnt_id];
          b_q  <= b_v[gnt_id];
          id_q <= gnt_id;
          cnt  <= CNT_W'(LATENCY-1);
        end
        EXEC: if (cnt == '0) begin
          rsp_data   <= a_q ^ b_q;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
`ifdef XOR_ARB_PARITY_EN
          rsp_parity <= ^(a_q ^ b_q);
`endif
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          // rsp_data/rsp_id keep the last result; only valid drops.
          rsp_valid <= 1'b0;
          last      <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule
